host_from_breakout: RTL and testbench

Host-side deserializer for the breakout-to-host serial link. It recovers frame alignment from the serial frame-clock line and deframes the two serial data lanes into parallel words. It then presents the breakout's digital port, button, and link-power bits as a registered sample with a one-cycle valid strobe. It sits in the host FPGA directly behind the IO input registers for the three link lines, and feeds the host's register/stream logic.

---
 rtl/host_from_breakout.sv | 141 ++++++++++++++
 tb/tb_host_from_breakout.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/host_from_breakout.sv
// Host-side deserializer for the breakout serial link: recovers frame alignment
// from the frame-clock lane and presents port/button/power words with a valid strobe.
module host_from_breakout #(
    parameter logic [9:0] SYNC_PATTERN  = 10'b1111100000,
    parameter int         LOCK_FRAMES   = 4,
    parameter int         UNLOCK_FRAMES = 3
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_clk_s,
    input  logic        i_d0_s,
    input  logic        i_d1_s,
    output logic [7:0]  o_port,
    output logic [5:0]  o_button,
    output logic [3:0]  o_link_pow,
    output logic        o_valid,
    output logic        o_locked,
    output logic [15:0] o_err_count
);

    localparam logic [3:0] LOCK_N   = 4'(LOCK_FRAMES);
    localparam logic [3:0] UNLOCK_N = 4'(UNLOCK_FRAMES);

    typedef enum logic [1:0] {
        HUNT,
        VERIFY,
        LOCKED
    } state_t;

    state_t     state;
    logic [9:0] hist_clk;
    logic [9:0] hist_d0;
    logic [9:0] hist_d1;
    logic [3:0] slot_cnt;
    logic [3:0] good_cnt;
    logic [3:0] miss_cnt;

    logic [9:0] word_clk;
    logic [9:0] word_d0;
    logic [9:0] word_d1;
    logic       good_frame;
    logic       wrap;

    // Oldest slot (s0) sits at bit 9; slots carry word bits in pairs swapped order.
    function automatic logic [9:0] to_word(input logic [9:0] h);
        return {h[8], h[9], h[6], h[7], h[4], h[5], h[2], h[3], h[0], h[1]};
    endfunction

    assign word_clk   = to_word(hist_clk);
    assign word_d0    = to_word(hist_d0);
    assign word_d1    = to_word(hist_d1);
    assign good_frame = (word_clk == SYNC_PATTERN) && (word_d0[9:8] == 2'b00);
    assign wrap       = (slot_cnt == 4'd9);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            hist_clk <= '0;
            hist_d0  <= '0;
            hist_d1  <= '0;
        end else begin
            hist_clk <= {hist_clk[8:0], i_clk_s};
            hist_d0  <= {hist_d0[8:0], i_d0_s};
            hist_d1  <= {hist_d1[8:0], i_d1_s};
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state       <= HUNT;
            slot_cnt    <= '0;
            good_cnt    <= '0;
            miss_cnt    <= '0;
            o_port      <= '0;
            o_button    <= '0;
            o_link_pow  <= '0;
            o_valid     <= 1'b0;
            o_locked    <= 1'b0;
            o_err_count <= '0;
        end else begin
            o_valid  <= 1'b0;
            slot_cnt <= wrap ? 4'd0 : slot_cnt + 4'd1;
            case (state)
                HUNT: begin
                    if (good_frame) begin
                        slot_cnt <= '0;
                        good_cnt <= 4'd1;
                        if (LOCK_N == 4'd1) begin
                            state    <= LOCKED;
                            o_locked <= 1'b1;
                            miss_cnt <= '0;
                        end else begin
                            state <= VERIFY;
                        end
                    end
                end
                VERIFY: begin
                    if (wrap) begin
                        if (good_frame) begin
                            good_cnt <= good_cnt + 4'd1;
                            if (good_cnt + 4'd1 == LOCK_N) begin
                                state    <= LOCKED;
                                o_locked <= 1'b1;
                                miss_cnt <= '0;
                            end
                        end else begin
                            state <= HUNT;
                        end
                    end
                end
                LOCKED: begin
                    if (wrap) begin
                        if (good_frame) begin
                            o_port     <= word_d1[9:2];
                            o_button   <= word_d0[7:2];
                            o_link_pow <= {word_d1[1:0], word_d0[1:0]};
                            o_valid    <= 1'b1;
                            miss_cnt   <= '0;
                        end else begin
                            if (o_err_count != 16'hFFFF) begin
                                o_err_count <= o_err_count + 16'd1;
                            end
                            // Error count and miss count advance together on a bad wrap.
                            if (miss_cnt + 4'd1 == UNLOCK_N) begin
                                state    <= HUNT;
                                o_locked <= 1'b0;
                                miss_cnt <= '0;
                            end else begin
                                miss_cnt <= miss_cnt + 4'd1;
                            end
                        end
                    end
                end
                default: begin
                    state    <= HUNT;
                    o_locked <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_host_from_breakout.sv
// Randomized bench for host_from_breakout: frame-level reference model compared
// against the DUT outputs every cycle, plus fixed scenario checkpoints.
module tb_host_from_breakout;

    localparam logic [9:0] SYNC     = 10'b1111100000;
    localparam int         LOCK_N   = 4;
    localparam int         UNLOCK_N = 3;
    localparam int         M_HUNT   = 0;
    localparam int         M_VERIFY = 1;
    localparam int         M_LOCKED = 2;

    logic        i_clk   = 1'b0;
    logic        i_rst_n = 1'b0;
    logic        i_clk_s = 1'b0;
    logic        i_d0_s  = 1'b0;
    logic        i_d1_s  = 1'b0;
    logic [7:0]  o_port;
    logic [5:0]  o_button;
    logic [3:0]  o_link_pow;
    logic        o_valid;
    logic        o_locked;
    logic [15:0] o_err_count;

    host_from_breakout #(
        .SYNC_PATTERN (SYNC),
        .LOCK_FRAMES  (LOCK_N),
        .UNLOCK_FRAMES(UNLOCK_N)
    ) dut (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_clk_s    (i_clk_s),
        .i_d0_s     (i_d0_s),
        .i_d1_s     (i_d1_s),
        .o_port     (o_port),
        .o_button   (o_button),
        .o_link_pow (o_link_pow),
        .o_valid    (o_valid),
        .o_locked   (o_locked),
        .o_err_count(o_err_count)
    );

    always #5 i_clk = ~i_clk;

    int errors     = 0;
    int checks     = 0;
    int valid_seen = 0;
    bit check_en   = 1'b0;

    // Slot k of a frame carries this word bit.
    function automatic int slot_bit(input int k);
        case (k)
            0: return 8;
            1: return 9;
            2: return 6;
            3: return 7;
            4: return 4;
            5: return 5;
            6: return 2;
            7: return 3;
            8: return 0;
            default: return 1;
        endcase
    endfunction

    function automatic logic [9:0] deframe(input logic [9:0] slots);
        logic [9:0] w;
        w = '0;
        for (int k = 0; k < 10; k++) w[slot_bit(k)] = slots[k];
        return w;
    endfunction

    function automatic logic [9:0] slotify(input logic [9:0] w);
        logic [9:0] s;
        s = '0;
        for (int k = 0; k < 10; k++) s[k] = w[slot_bit(k)];
        return s;
    endfunction

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors <= 40)
                $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: slot arrays indexed by position in frame (index 9 newest),
    // mode plus a countdown to the next frame boundary.
    logic [9:0]  mh_c = '0, mh_0 = '0, mh_1 = '0;
    logic [9:0]  mw_c, mw_0, mw_1;
    bit          m_good;
    int          m_mode = M_HUNT, m_next = 0, m_goods = 0, m_miss = 0;
    logic [7:0]  e_port = '0;
    logic [5:0]  e_button = '0;
    logic [3:0]  e_pow = '0;
    logic        e_valid = 1'b0, e_locked = 1'b0;
    logic [15:0] e_err = '0;

    always @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            mh_c = '0; mh_0 = '0; mh_1 = '0;
            m_mode = M_HUNT; m_next = 0; m_goods = 0; m_miss = 0;
            e_port = '0; e_button = '0; e_pow = '0;
            e_valid = 1'b0; e_locked = 1'b0; e_err = '0;
        end else begin
            mw_c   = deframe(mh_c);
            mw_0   = deframe(mh_0);
            mw_1   = deframe(mh_1);
            m_good = (mw_c == SYNC) && (mw_0[9:8] == 2'b00);
            e_valid = 1'b0;
            if (m_mode == M_HUNT) begin
                if (m_good) begin
                    m_next  = 10;
                    m_goods = 1;
                    m_miss  = 0;
                    m_mode  = (m_goods >= LOCK_N) ? M_LOCKED : M_VERIFY;
                end
            end else begin
                m_next--;
                if (m_next == 0) begin
                    m_next = 10;
                    if (m_mode == M_VERIFY) begin
                        if (m_good) begin
                            m_goods++;
                            if (m_goods >= LOCK_N) m_mode = M_LOCKED;
                        end else begin
                            m_mode = M_HUNT;
                        end
                    end else if (m_good) begin
                        e_port   = mw_1[9:2];
                        e_button = mw_0[7:2];
                        e_pow    = {mw_1[1:0], mw_0[1:0]};
                        e_valid  = 1'b1;
                        m_miss   = 0;
                    end else begin
                        if (e_err != 16'hFFFF) e_err = e_err + 16'd1;
                        m_miss++;
                        if (m_miss >= UNLOCK_N) m_mode = M_HUNT;
                    end
                end
            end
            e_locked = (m_mode == M_LOCKED);
            mh_c = {i_clk_s, mh_c[9:1]};
            mh_0 = {i_d0_s, mh_0[9:1]};
            mh_1 = {i_d1_s, mh_1[9:1]};
        end
    end

    always @(negedge i_clk) begin
        if (check_en) begin
            check("valid", 16'(o_valid), 16'(e_valid));
            check("locked", 16'(o_locked), 16'(e_locked));
            check("port", 16'(o_port), 16'(e_port));
            check("button", 16'(o_button), 16'(e_button));
            check("link_pow", 16'(o_link_pow), 16'(e_pow));
            check("err_count", o_err_count, e_err);
            if (o_valid === 1'b1) valid_seen++;
        end
    end

    task automatic send_slot(input logic c, input logic a, input logic b);
        @(negedge i_clk);
        i_clk_s = c;
        i_d0_s  = a;
        i_d1_s  = b;
    endtask

    task automatic send_frame(input logic [7:0] port, input logic [5:0] btn, input logic [3:0] pow,
                              input logic [1:0] rsv, input int flip_slot);
        logic [9:0] sc, s0, s1;
        sc = slotify(SYNC);
        s0 = slotify({rsv, btn, pow[1:0]});
        s1 = slotify({port, pow[3:2]});
        if (flip_slot >= 0 && flip_slot < 10) sc[flip_slot] = ~sc[flip_slot];
        for (int k = 0; k < 10; k++) send_slot(sc[k], s0[k], s1[k]);
    endtask

    task automatic applyStimulus_good(input int n);
        for (int i = 0; i < n; i++) send_frame(8'hA5, 6'h2A, 4'b1001, 2'b00, -1);
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish, expected finish");
        $fatal(1);
    end

    initial begin
        repeat (2) @(negedge i_clk);
        check("reset_locked", 16'(o_locked), 16'h0);
        check("reset_valid", 16'(o_valid), 16'h0);
        check("reset_port", 16'(o_port), 16'h0);
        check("reset_err", o_err_count, 16'h0);
        i_rst_n  = 1'b1;
        check_en = 1'b1;

        // Idle lines never produce lock or strobes.
        for (int i = 0; i < 100; i++) send_slot(1'b0, 1'b0, 1'b0);
        check("idle_locked", 16'(o_locked), 16'h0);
        check("idle_valid_seen", 16'(valid_seen), 16'h0);
        check("idle_err", o_err_count, 16'h0);

        // Lock from an arbitrary offset; frames 5 and 6 strobe by end of frame 7.
        for (int i = 0; i < int'($urandom_range(0, 9)); i++) send_slot(1'b0, 1'b0, 1'b0);
        valid_seen = 0;
        applyStimulus_good(7);
        check("lock_valid_seen", 16'(valid_seen), 16'd2);
        check("lock_locked", 16'(o_locked), 16'h1);
        check("lock_port", 16'(o_port), 16'h00A5);
        check("lock_button", 16'(o_button), 16'h002A);
        check("lock_pow", 16'(o_link_pow), 16'h0009);
        check("lock_err", o_err_count, 16'h0);

        // Corrupted frame-clock slot s4.
        valid_seen = 0;
        send_frame(8'hA5, 6'h2A, 4'b1001, 2'b00, 4);
        send_frame(8'hA5, 6'h2A, 4'b1001, 2'b00, -1);
        check("clkerr_err", o_err_count, 16'd1);
        check("clkerr_locked", 16'(o_locked), 16'h1);
        check("clkerr_valid_seen", 16'(valid_seen), 16'd1);
        applyStimulus_good(1);
        check("clkerr_recover_valid", 16'(valid_seen), 16'd2);

        // Reserved bit w9 set: two misses hold lock, third drops it.
        valid_seen = 0;
        for (int i = 0; i < 3; i++) send_frame(8'hA5, 6'h2A, 4'b1001, 2'b10, -1);
        check("rsv_err_two", o_err_count, 16'd3);
        check("rsv_locked_held", 16'(o_locked), 16'h1);
        check("rsv_valid_seen", 16'(valid_seen), 16'd1);
        applyStimulus_good(1);
        check("rsv_unlocked", 16'(o_locked), 16'h0);
        check("rsv_err_three", o_err_count, 16'd4);
        check("rsv_port_hold", 16'(o_port), 16'h00A5);
        applyStimulus_good(4);
        check("relock_locked", 16'(o_locked), 16'h1);
        check("relock_valid_seen", 16'(valid_seen), 16'd1);

        // Asynchronous reset mid-frame while locked.
        for (int i = 0; i < 4; i++) send_slot(1'b1, 1'b1, 1'b1);
        @(negedge i_clk);
        #2 i_rst_n = 1'b0;
        #1;
        check("rst_port", 16'(o_port), 16'h0);
        check("rst_button", 16'(o_button), 16'h0);
        check("rst_pow", 16'(o_link_pow), 16'h0);
        check("rst_locked", 16'(o_locked), 16'h0);
        check("rst_err", o_err_count, 16'h0);
        @(negedge i_clk);
        i_rst_n = 1'b1;

        // Slip by one slot while verifying delays lock with no strobes.
        valid_seen = 0;
        for (int i = 0; i < 2; i++) send_frame(8'h3C, 6'h15, 4'h6, 2'b00, -1);
        send_slot(1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) send_frame(8'h3C, 6'h15, 4'h6, 2'b00, -1);
        check("slip_locked", 16'(o_locked), 16'h0);
        check("slip_valid_seen", 16'(valid_seen), 16'd0);
        for (int i = 0; i < 2; i++) send_frame(8'h3C, 6'h15, 4'h6, 2'b00, -1);
        check("slip_relocked", 16'(o_locked), 16'h1);
        check("slip_no_early_valid", 16'(valid_seen), 16'd0);
        send_frame(8'h3C, 6'h15, 4'h6, 2'b00, -1);
        check("slip_first_valid", 16'(valid_seen), 16'd1);
        check("slip_port", 16'(o_port), 16'h003C);
        check("slip_button", 16'(o_button), 16'h0015);
        check("slip_pow", 16'(o_link_pow), 16'h0006);

        // Random traffic: good frames, noise slots, clock-slot flips, reserved bits.
        for (int i = 0; i < 250; i++) begin
            int r;
            r = int'($urandom_range(0, 99));
            if (r < 8) begin
                for (int j = 0; j < int'($urandom_range(1, 3)); j++)
                    send_slot(1'($urandom), 1'($urandom), 1'($urandom));
            end else if (r < 14) begin
                send_frame(8'($urandom), 6'($urandom), 4'($urandom), 2'b00, int'($urandom_range(0, 9)));
            end else if (r < 20) begin
                send_frame(8'($urandom), 6'($urandom), 4'($urandom), 2'($urandom_range(1, 3)), -1);
            end else begin
                send_frame(8'($urandom), 6'($urandom), 4'($urandom), 2'b00, -1);
            end
        end
        repeat (3) @(negedge i_clk);
        check_en = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
